text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
// PURPOSE
//  Upstream feeder for the 80x60 character-map display RAM (write port, CLK_50M domain).
//  Accepts a byte stream over a valid/ready handshake and keeps a cursor.
//  Printable bytes become glyph writes at the cursor; a small control-code set moves the cursor or clears the screen.
//  Drives mem_addr/mem_we/mem_data straight into the VGA text block's map RAM port A.
// PARAMETERS
//  COLS            80     visible columns; col field is 7 bits
//  ROWS            60     visible rows; row field is 6 bits
//  FILL_CHAR       8'h20  glyph written by every clear operation
//  CLEAR_ON_RESET  1      1: full-screen clear after reset; 0: go straight to IDLE
// PORTS
//  CLK_50M     in   1   system clock, same clock as the map RAM write port
//  RST         in   1   asynchronous, active-high reset
//  char_valid  in   1   char_data is valid
//  char_data   in   8   byte to print or control code
//  char_ready  out  1   byte accepted on a cycle where char_valid && char_ready
//  mem_addr    out  13  {row[5:0], col[6:0]}
//  mem_we      out  1   one-cycle write strobe
//  mem_data    out  8   glyph code
//  cursor_col  out  7   current column, 0..COLS-1
//  cursor_row  out  6   current row, 0..ROWS-1
//  busy        out  1   high while a clear sweep is running
// BEHAVIOUR
//  Reset values: mem_we=0, mem_addr=0, mem_data=FILL_CHAR, cursor=(0,0), char_ready=0.
//   busy=CLEAR_ON_RESET. State=CLR_ALL if CLEAR_ON_RESET, else IDLE.
//  States:
//   IDLE: char_ready=1.
//   CLR_ALL: sweeps every (row,col) in row-major order, one write per cycle, then -> IDLE with cursor (0,0).
//   CLR_LINE: sweeps cols 0..COLS-1 of cursor_row, then -> IDLE.
//   char_ready=0 in both clear states. Input is held off and never dropped.
//  All outputs are registered. A byte accepted in cycle N gives its mem_we pulse in cycle N+1.
//   mem_addr in that pulse is the pre-advance cursor. Throughput is 1 byte/cycle in IDLE.
//  Codes accepted in IDLE:
//   0x0D CR: col=0. No write.
//   0x0A LF: col=0, row+1. No write.
//   0x08 BS: if col>0, col-1 and write FILL_CHAR at the new col. At col 0: no move, no write.
//   0x0C FF: -> CLR_ALL, cursor home.
//   0x00-0x1F other: ignored. The byte is consumed, no write.
//   All other bytes (0x20-0xFF): write at cursor, then col+1.
//  Wrap rules:
//   col==COLS-1 after a write -> col=0, row+1.
//   row==ROWS-1 with row+1 -> row=0, then handle per CLEAR_ON_WRAP_EN.
//  Never addresses col>=COLS or row>=ROWS. Addresses 80..127 in a row are never written.
//  RST asserted mid-sweep: abort at once, re-enter the reset state and restart the sweep from (0,0).
// CONFIGURATION
//  `CLEAR_ON_WRAP_EN defined:
//   - any row advance (LF or column wrap) enters CLR_LINE for the new row before further input.
//   - the old text in that row is erased; cost is COLS cycles with char_ready=0.
//  Not defined:
//   - row advance never clears and never drops char_ready.
//   - new text overwrites old glyphs cell by cell.
// STRUCTURE
//  Package text_console_pkg holds:
//   - localparams CC_CR, CC_LF, CC_BS, CC_FF
//   - COLS_DEF, ROWS_DEF
//   - the state enum {IDLE, CLR_ALL, CLR_LINE}
//   - the addr-pack function {row,col}
//  Sub-module console_sweep_ctr: row/col sweep counter with start, line-only mode and done.
//   Shared by CLR_ALL and CLR_LINE.
// TESTING
//  1. Reset, CLEAR_ON_RESET=1: exactly 4800 mem_we pulses of 0x20.
//     Addresses from 0x0000 to {59,79}=0x1DCF; col never >79. Then char_ready=1, busy=0.
//  2. Send 'A','B' back-to-back: writes 0x41@0x0000 then 0x42@0x0001 on consecutive cycles.
//     Cursor ends at (0,2).
//  3. Cursor (0,79), send 'Z': write 0x5A@0x004F, cursor -> (1,0).
//     With `CLEAR_ON_WRAP_EN: 80 writes of 0x20 to 0x0080..0x00CF follow, char_ready low throughout.
//  4. Cursor (59,10), send LF: cursor -> (0,0).
//     Without the macro: no write, char_ready stays 1.
//  5. BS at (3,5): write 0x20@0x0184, cursor (3,4). BS at (3,0): no write, cursor unchanged.
//  6. FF with char_valid held high: char_ready low for 4800 cycles.
//     Next byte is written at 0x0000. RST pulse mid-sweep restarts the sweep from 0x0000.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and address packing for the text console writer.
package text_console_pkg;

  localparam int unsigned COLS_DEF = 80;
  localparam int unsigned ROWS_DEF = 60;
  localparam int unsigned COL_W    = 7;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned ADDR_W   = ROW_W + COL_W;
  localparam int unsigned BYTE_W   = 8;

  localparam logic [BYTE_W-1:0] CC_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] CC_LF = 8'h0A;
  localparam logic [BYTE_W-1:0] CC_BS = 8'h08;
  localparam logic [BYTE_W-1:0] CC_FF = 8'h0C;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_ALL  = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

  // Map RAM address is the row in the upper bits, column in the lower 7.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_console_writer_sweep.sv
// Row/column sweep counter used by both the full-screen and single-line clears.
module console_sweep_ctr
  import text_console_pkg::*;
#(
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned ROWS         = ROWS_DEF,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             line_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             done_c_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             run_q;
  logic             line_q;
  logic             col_last_c;
  logic             row_last_c;

  assign col_last_c = (col_q == COL_W'(COLS - 1));
  assign row_last_c = (row_q == ROW_W'(ROWS - 1));
  // Final cell of the sweep is being visited this cycle.
  assign done_c_o   = run_q && col_last_c && (line_q || row_last_c);
  assign row_o      = row_q;
  assign col_o      = col_q;

  // Walk row-major; line mode stops at the end of the starting row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q  <= '0;
      col_q  <= '0;
      run_q  <= RUN_ON_RESET;
      line_q <= 1'b0;
    end else if (start_i) begin
      row_q  <= line_i ? row_i : '0;
      col_q  <= '0;
      run_q  <= 1'b1;
      line_q <= line_i;
    end else if (run_q) begin
      if (col_last_c) begin
        col_q <= '0;
        if (done_c_o) begin
          run_q <= 1'b0;
        end else begin
          row_q <= row_q + ROW_W'(1);
        end
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream console front end driving the character-map RAM write port.
// Optional build macro CLEAR_ON_WRAP_EN: every row advance clears the new row first.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int unsigned       COLS           = COLS_DEF,
  parameter int unsigned       ROWS           = ROWS_DEF,
  parameter logic [BYTE_W-1:0] FILL_CHAR      = 8'h20,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK_50M,
  input  logic              RST,
  input  logic              char_valid,
  input  logic [BYTE_W-1:0] char_data,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              ready_q;
  logic              busy_q;

  logic              accept_c;
  logic              adv_row_c;
  logic              sweep_start_c;
  logic              sweep_line_c;
  logic [ROW_W-1:0]  sweep_row;
  logic [COL_W-1:0]  sweep_col;
  logic              sweep_done_c;

  console_sweep_ctr #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .RUN_ON_RESET (CLEAR_ON_RESET)
  ) u_sweep (
    .clk_i    (CLK_50M),
    .rst_i    (RST),
    .start_i  (sweep_start_c),
    .line_i   (sweep_line_c),
    .row_i    (row_d),
    .row_o    (sweep_row),
    .col_o    (sweep_col),
    .done_c_o (sweep_done_c)
  );

  assign accept_c = char_valid && ready_q && (state_q == IDLE);

  // Byte decode, cursor movement and clear sequencing.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    adv_row_c     = 1'b0;
    sweep_start_c = 1'b0;
    sweep_line_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (char_data >= 8'h20) begin
            we_d   = 1'b1;
            addr_d = pack_addr(row_q, col_q);
            data_d = char_data;
            if (col_q == COL_W'(COLS - 1)) begin
              col_d     = '0;
              adv_row_c = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (char_data == CC_CR) begin
            col_d = '0;
          end else if (char_data == CC_LF) begin
            col_d     = '0;
            adv_row_c = 1'b1;
          end else if (char_data == CC_BS) begin
            if (col_q != '0) begin
              col_d  = col_q - COL_W'(1);
              we_d   = 1'b1;
              addr_d = pack_addr(row_q, col_q - COL_W'(1));
              data_d = FILL_CHAR;
            end
          end else if (char_data == CC_FF) begin
            col_d         = '0;
            row_d         = '0;
            state_d       = CLR_ALL;
            sweep_start_c = 1'b1;
          end
          if (adv_row_c) begin
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
`ifdef CLEAR_ON_WRAP_EN
            state_d       = CLR_LINE;
            sweep_start_c = 1'b1;
            sweep_line_c  = 1'b1;
`endif
          end
        end
      end
      CLR_ALL, CLR_LINE: begin
        we_d   = 1'b1;
        addr_d = pack_addr(sweep_row, sweep_col);
        data_d = FILL_CHAR;
        if (sweep_done_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, cursor and RAM port registers.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= FILL_CHAR;
      ready_q <= 1'b0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign char_ready = ready_q;
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_data   = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer.
module tb_text_console_writer;

  logic        CLK_50M = 1'b0;
  logic        RST;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_data;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int tcount = 0;

  logic [12:0] q_addr[$];
  logic [7:0]  q_data[$];
  int          q_t[$];

  text_console_writer dut (
    .CLK_50M    (CLK_50M),
    .RST        (RST),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_data   (mem_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 CLK_50M = ~CLK_50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and log any write pulse seen just after the edge.
  task automatic tick();
    @(posedge CLK_50M);
    #1;
    tcount++;
    if (mem_we === 1'b1) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_data);
      q_t.push_back(tcount);
    end
  endtask

  task automatic qclear();
    q_addr.delete();
    q_data.delete();
    q_t.delete();
  endtask

  // Present one byte until it is taken by an edge with char_ready high.
  task automatic send(input logic [7:0] b);
    int    n;
    logic  was;
    char_valid = 1'b1;
    char_data  = b;
    n = 0;
    do begin
      was = char_ready;
      tick();
      n++;
    end while (!was && n < 20000);
    if (!was) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=accept", n);
    end
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (char_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;
    RST        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;

    // 1. reset values and power-up clear
    repeat (3) tick();
    check("rst_we",    32'(mem_we), 32'h0);
    check("rst_addr",  32'(mem_addr), 32'h0);
    check("rst_data",  32'(mem_data), 32'h20);
    check("rst_col",   32'(cursor_col), 32'h0);
    check("rst_row",   32'(cursor_row), 32'h0);
    check("rst_ready", 32'(char_ready), 32'h0);
    check("rst_busy",  32'(busy), 32'h1);
    RST = 1'b0;
    qclear();
    wait_ready(6000, n);
    tick();
    check("clr_all_count", 32'(q_addr.size()), 32'd4800);
    bad = 0;
    for (int i = 0; i < q_addr.size(); i++) begin
      if (q_addr[i] !== 13'((i / 80) * 128 + (i % 80)) || q_data[i] !== 8'h20) bad++;
    end
    check("clr_all_seq", 32'(bad), 32'h0);
    check("clr_all_first", 32'(q_addr[0]), 32'h0000);
    check("clr_all_last", 32'(q_addr[q_addr.size()-1]), 32'h1DCF);
    check("clr_all_ready", 32'(char_ready), 32'h1);
    check("clr_all_busy", 32'(busy), 32'h0);

    // 2. back-to-back printable bytes
    qclear();
    send(8'h41);
    send(8'h42);
    check("ab_count", 32'(q_addr.size()), 32'd2);
    check("ab_addr0", 32'(q_addr[0]), 32'h0000);
    check("ab_data0", 32'(q_data[0]), 32'h41);
    check("ab_addr1", 32'(q_addr[1]), 32'h0001);
    check("ab_data1", 32'(q_data[1]), 32'h42);
    check("ab_consec", 32'(q_t[1] - q_t[0]), 32'd1);
    check("ab_col", 32'(cursor_col), 32'd2);
    check("ab_row", 32'(cursor_row), 32'd0);

    // 3. column wrap at col 79
    for (int i = 0; i < 77; i++) send(8'h61);
    check("pre_wrap_col", 32'(cursor_col), 32'd79);
    qclear();
    send(8'h5A);
    tick();
    check("wrap_addr", 32'(q_addr[0]), 32'h004F);
    check("wrap_data", 32'(q_data[0]), 32'h5A);
    check("wrap_col", 32'(cursor_col), 32'd0);
    check("wrap_row", 32'(cursor_row), 32'd1);
`ifdef CLEAR_ON_WRAP_EN
    check("wrap_clr_ready", 32'(char_ready), 32'h0);
    wait_ready(200, n);
    tick();
    check("wrap_clr_count", 32'(q_addr.size()), 32'd81);
    bad = 0;
    for (int i = 1; i < q_addr.size(); i++) begin
      if (q_addr[i] !== 13'(32'h80 + i - 1) || q_data[i] !== 8'h20) bad++;
    end
    check("wrap_clr_seq", 32'(bad), 32'h0);
`else
    check("wrap_ready", 32'(char_ready), 32'h1);
    check("wrap_nowrite", 32'(q_addr.size()), 32'd1);
`endif

    // 4. LF from the last row wraps to the top
    for (int i = 0; i < 58; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h78);
    check("pre_lf_row", 32'(cursor_row), 32'd59);
    check("pre_lf_col", 32'(cursor_col), 32'd10);
    wait_ready(200, n);
    qclear();
    send(8'h0A);
    check("lf_row", 32'(cursor_row), 32'd0);
    check("lf_col", 32'(cursor_col), 32'd0);
`ifndef CLEAR_ON_WRAP_EN
    tick();
    check("lf_nowrite", 32'(q_addr.size()), 32'd0);
    check("lf_ready", 32'(char_ready), 32'h1);
`endif

    // 5. backspace, CR and ignored control codes
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h79);
    wait_ready(200, n);
    qclear();
    send(8'h08);
    check("bs_count", 32'(q_addr.size()), 32'd1);
    check("bs_addr", 32'(q_addr[0]), 32'h0184);
    check("bs_data", 32'(q_data[0]), 32'h20);
    check("bs_col", 32'(cursor_col), 32'd4);
    check("bs_row", 32'(cursor_row), 32'd3);
    send(8'h0D);
    check("cr_col", 32'(cursor_col), 32'd0);
    qclear();
    send(8'h08);
    send(8'h01);
    tick();
    check("bs0_nowrite", 32'(q_addr.size()), 32'd0);
    check("bs0_col", 32'(cursor_col), 32'd0);
    check("bs0_row", 32'(cursor_row), 32'd3);

    // 6. form feed with the next byte already waiting
    qclear();
    check("ff_ready_pre", 32'(char_ready), 32'h1);
    char_valid = 1'b1;
    char_data  = 8'h0C;
    tick();
    char_data  = 8'h51;
    n = 0;
    while (char_ready !== 1'b1 && n < 6000) begin
      if (n == 10) check("ff_busy", 32'(busy), 32'h1);
      n++;
      tick();
    end
    check("ff_ready_low", 32'(n), 32'd4800);
    check("ff_count", 32'(q_addr.size()), 32'd4800);
    tick();
    char_valid = 1'b0;
    check("ff_next_addr", 32'(q_addr[q_addr.size()-1]), 32'h0000);
    check("ff_next_data", 32'(q_data[q_data.size()-1]), 32'h51);
    check("ff_next_col", 32'(cursor_col), 32'd1);

    // reset pulse in the middle of a sweep restarts it
    send(8'h0C);
    repeat (100) tick();
    RST = 1'b1;
    #2;
    check("mid_rst_we", 32'(mem_we), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h1);
    check("mid_rst_ready", 32'(char_ready), 32'h0);
    tick();
    RST = 1'b0;
    qclear();
    wait_ready(6000, n);
    tick();
    check("mid_rst_count", 32'(q_addr.size()), 32'd4800);
    check("mid_rst_first", 32'(q_addr[0]), 32'h0000);
    check("mid_rst_second", 32'(q_addr[1]), 32'h0001);
    check("mid_rst_col", 32'(cursor_col), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
